// File: rtl/tlight_monitor.sv
// Passive checker for the ns/we traffic-light bus: tracks the Y_A->RG->Y_B->GR phase
// sequence, checks phase durations and flags illegal or out-of-order light patterns.
module tlight_monitor #(
   parameter int YELLOW_DURATION    = 3,
   parameter int RED_GREEN_DURATION = 15,
   parameter int CNT_W              = 5
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [2:0]  ns,
   input  logic [2:0]  we,
   input  logic        clr_errors,
   output logic        locked,
   output logic [1:0]  phase,
   output logic        err_illegal,
   output logic        err_seq,
   output logic        err_timing,
   output logic [7:0]  error_count,
   output logic [15:0] cycles_done
);

   localparam logic [2:0] RED = 3'b100;
   localparam logic [2:0] YEL = 3'b010;
   localparam logic [2:0] GRN = 3'b001;

   localparam logic [5:0] PAT_YY = {YEL, YEL};
   localparam logic [5:0] PAT_RG = {RED, GRN};
   localparam logic [5:0] PAT_GR = {GRN, RED};

   localparam logic [1:0] PH_YA = 2'd0;
   localparam logic [1:0] PH_RG = 2'd1;
   localparam logic [1:0] PH_YB = 2'd2;
   localparam logic [1:0] PH_GR = 2'd3;

   localparam logic [CNT_W-1:0] Y_LEN  = CNT_W'(YELLOW_DURATION + 1);
   localparam logic [CNT_W-1:0] RG_LEN = CNT_W'(RED_GREEN_DURATION + 1);

   logic              locked_q, locked_d;
   logic [1:0]        phase_q, phase_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              ill_q, ill_d, seq_q, seq_d, tim_q, tim_d;
   logic [7:0]        ecnt_q, ecnt_d;
   logic [15:0]       cyc_q, cyc_d;
   logic [5:0]        prev_q;

   logic [5:0]        sample, cur_pat, nxt_pat;
   logic [1:0]        next_phase;
   logic [CNT_W-1:0]  len;
   logic              legal, set_ill, set_seq, set_tim;
   logic [7:0]        ecnt_base;

   function automatic logic [5:0] phase_pat(input logic [1:0] p);
      case (p)
         PH_RG:   phase_pat = PAT_RG;
         PH_GR:   phase_pat = PAT_GR;
         default: phase_pat = PAT_YY;
      endcase
   endfunction

   assign sample     = {ns, we};
   assign legal      = (sample == PAT_YY) || (sample == PAT_RG) || (sample == PAT_GR);
   assign next_phase = phase_q + 2'd1;
   assign cur_pat    = phase_pat(phase_q);
   assign nxt_pat    = phase_pat(next_phase);
   // Odd phases are the red/green ones.
   assign len        = phase_q[0] ? RG_LEN : Y_LEN;

   always_comb begin
      locked_d = locked_q;
      phase_d  = phase_q;
      cnt_d    = cnt_q;
      cyc_d    = cyc_q;
      set_ill  = 1'b0;
      set_seq  = 1'b0;
      set_tim  = 1'b0;
      if (!legal) begin
         set_ill  = 1'b1;
         locked_d = 1'b0;
      end else if (locked_q) begin
         if (sample == cur_pat) begin
            if (cnt_q < len) begin
               cnt_d = cnt_q + CNT_W'(1);
            end else begin
               set_tim  = 1'b1;
               locked_d = 1'b0;
            end
         end else if (sample == nxt_pat) begin
            set_tim = (cnt_q != len);
            phase_d = next_phase;
            cnt_d   = CNT_W'(1);
            if (phase_q == PH_GR) cyc_d = cyc_q + 16'd1;
         end else begin
            set_seq  = 1'b1;
            locked_d = 1'b0;
         end
      end else if (prev_q == PAT_YY && sample != PAT_YY) begin
         // Yellow alone is ambiguous (Y_A vs Y_B); the colour after it decides.
         locked_d = 1'b1;
         cnt_d    = CNT_W'(1);
         phase_d  = (sample == PAT_RG) ? PH_RG : PH_GR;
      end
   end

   always_comb begin
      ill_d     = (ill_q & ~clr_errors) | set_ill;
      seq_d     = (seq_q & ~clr_errors) | set_seq;
      tim_d     = (tim_q & ~clr_errors) | set_tim;
      ecnt_base = clr_errors ? 8'd0 : ecnt_q;
      ecnt_d    = ecnt_base;
      if ((set_ill | set_seq | set_tim) && ecnt_base != 8'hFF) ecnt_d = ecnt_base + 8'd1;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         locked_q <= 1'b1;
         phase_q  <= PH_YA;
         cnt_q    <= '0;
         ill_q    <= 1'b0;
         seq_q    <= 1'b0;
         tim_q    <= 1'b0;
         ecnt_q   <= 8'd0;
         cyc_q    <= 16'd0;
         prev_q   <= PAT_YY;
      end else begin
         locked_q <= locked_d;
         phase_q  <= phase_d;
         cnt_q    <= cnt_d;
         ill_q    <= ill_d;
         seq_q    <= seq_d;
         tim_q    <= tim_d;
         ecnt_q   <= ecnt_d;
         cyc_q    <= cyc_d;
         prev_q   <= sample;
      end
   end

   assign locked      = locked_q;
   assign phase       = phase_q;
   assign err_illegal = ill_q;
   assign err_seq     = seq_q;
   assign err_timing  = tim_q;
   assign error_count = ecnt_q;
   assign cycles_done = cyc_q;

endmodule

// File: tb/tb_tlight_monitor.sv
// Bench for tlight_monitor: scripted scenarios plus randomized controller-like traffic,
// checked every cycle against a phase-level reference model.
module tb_tlight_monitor;

   localparam logic [2:0] R = 3'b100;
   localparam logic [2:0] Y = 3'b010;
   localparam logic [2:0] G = 3'b001;
   localparam int YL = 4;
   localparam int RGL = 16;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic [2:0]  ns = Y, we = Y;
   logic        clr_errors = 1'b0;
   logic        locked, err_illegal, err_seq, err_timing;
   logic [1:0]  phase;
   logic [7:0]  error_count;
   logic [15:0] cycles_done;

   int n_cmp = 0, n_fail = 0;

   // reference model state
   int m_ph, m_cnt, m_ec, m_cd;
   bit m_lock, m_ei, m_es, m_et;
   logic [2:0] m_pns, m_pwe;

   tlight_monitor dut (
      .clock(clock), .reset_n(reset_n), .ns(ns), .we(we), .clr_errors(clr_errors),
      .locked(locked), .phase(phase), .err_illegal(err_illegal), .err_seq(err_seq),
      .err_timing(err_timing), .error_count(error_count), .cycles_done(cycles_done)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int plen(input int p);
      return (p % 2 == 0) ? YL : RGL;
   endfunction

   // Light pattern each phase shows: 0/2 yellow-yellow, 1 ns red we green, 3 ns green we red.
   function automatic logic [5:0] pat(input int p);
      case (p % 4)
         1: return {R, G};
         3: return {G, R};
         default: return {Y, Y};
      endcase
   endfunction

   function automatic bit is_legal(input logic [2:0] n, input logic [2:0] w);
      return ({n, w} == {Y, Y}) || ({n, w} == {R, G}) || ({n, w} == {G, R});
   endfunction

   task automatic model_reset();
      m_ph = 0; m_cnt = 0; m_ec = 0; m_cd = 0;
      m_lock = 1; m_ei = 0; m_es = 0; m_et = 0;
      m_pns = Y; m_pwe = Y;
   endtask

   task automatic model_step(input logic [2:0] n, input logic [2:0] w, input bit clr);
      int e = 0;  // 0 none, 1 illegal, 2 sequence, 3 timing
      if (!is_legal(n, w)) begin
         e = 1; m_lock = 0;
      end else if (m_lock) begin
         if ({n, w} == pat(m_ph)) begin
            if (m_cnt < plen(m_ph)) m_cnt++;
            else begin e = 3; m_lock = 0; end
         end else if ({n, w} == pat(m_ph + 1)) begin
            if (m_cnt != plen(m_ph)) e = 3;
            if (m_ph == 3) m_cd = (m_cd + 1) % 65536;
            m_ph = (m_ph + 1) % 4;
            m_cnt = 1;
         end else begin
            e = 2; m_lock = 0;
         end
      end else if ({m_pns, m_pwe} == {Y, Y} && {n, w} != {Y, Y}) begin
         m_lock = 1; m_cnt = 1;
         m_ph = ({n, w} == {R, G}) ? 1 : 3;
      end
      if (clr) begin m_ei = 0; m_es = 0; m_et = 0; m_ec = 0; end
      if (e == 1) m_ei = 1;
      if (e == 2) m_es = 1;
      if (e == 3) m_et = 1;
      if (e != 0 && m_ec < 255) m_ec++;
      m_pns = n; m_pwe = w;
   endtask

   always @(negedge clock) begin
      chk("locked", locked, m_lock);
      chk("phase", phase, m_ph);
      chk("err_illegal", err_illegal, m_ei);
      chk("err_seq", err_seq, m_es);
      chk("err_timing", err_timing, m_et);
      chk("error_count", error_count, m_ec);
      chk("cycles_done", cycles_done, m_cd);
   end

   // Drive one sample; returns at the following falling edge with outputs settled.
   task automatic cycle(input logic [2:0] n, input logic [2:0] w, input bit clr = 0);
      ns = n; we = w; clr_errors = clr;
      @(posedge clock);
      if (reset_n) model_step(n, w, clr);
      @(negedge clock);
   endtask

   task automatic hold(input logic [5:0] p, input int k);
      for (int i = 0; i < k; i++) cycle(p[5:3], p[2:0]);
   endtask

   task automatic ideal_cycle();
      hold(pat(0), YL); hold(pat(1), RGL); hold(pat(2), YL); hold(pat(3), RGL);
   endtask

   task automatic do_reset();
      #2 reset_n = 1'b0;
      model_reset();
      #1;
      chk("rst_locked", locked, 1);
      chk("rst_phase", phase, 0);
      chk("rst_count", error_count, 0);
      chk("rst_cycles", cycles_done, 0);
      ns = Y; we = Y; clr_errors = 0;
      @(negedge clock); @(negedge clock);
      reset_n = 1'b1;
   endtask

   function automatic logic [5:0] rand_illegal();
      logic [5:0] v;
      do v = 6'($urandom); while (is_legal(v[5:3], v[2:0]));
      return v;
   endfunction

   initial begin
      logic [5:0] v;
      model_reset();
      @(negedge clock); @(negedge clock);
      reset_n = 1'b1;

      // T1: two ideal cycles, second GR->Y_A transition on the next yellow sample
      ideal_cycle(); ideal_cycle(); hold(pat(0), 1);
      chk("t1_cycles", cycles_done, 2);
      chk("t1_errors", error_count, 0);
      chk("t1_locked", locked, 1);

      // T2: GG during RG
      do_reset();
      hold(pat(0), YL); hold(pat(1), 5);
      cycle(G, G);
      chk("t2_illegal", err_illegal, 1);
      chk("t2_count", error_count, 1);
      chk("t2_locked", locked, 0);
      hold(pat(0), 1); hold(pat(1), 1);
      chk("t2_relock", locked, 1);
      chk("t2_phase", phase, 1);

      // T3: short yellow
      do_reset();
      hold(pat(0), 3); hold(pat(1), 1);
      chk("t3_timing", err_timing, 1);
      chk("t3_locked", locked, 1);
      chk("t3_phase", phase, 1);
      chk("t3_count", error_count, 1);

      // T4: RG overrun then relock into GR
      do_reset();
      hold(pat(0), YL); hold(pat(1), 16);
      chk("t4_no_err_yet", err_timing, 0);
      hold(pat(1), 1);
      chk("t4_timing", err_timing, 1);
      chk("t4_unlocked", locked, 0);
      hold(pat(0), 4); hold(pat(3), 1);
      chk("t4_relock", locked, 1);
      chk("t4_phase", phase, 3);

      // T5: out-of-sequence, saturation, clear
      do_reset();
      hold(pat(0), YL); hold(pat(3), 1);
      chk("t5_seq", err_seq, 1);
      chk("t5_unlocked", locked, 0);
      for (int i = 0; i < 300; i++) begin
         v = rand_illegal();
         cycle(v[5:3], v[2:0]);
      end
      chk("t5_saturate", error_count, 255);
      cycle(Y, Y, 1'b1);
      chk("t5_clr_count", error_count, 0);
      chk("t5_clr_ill", err_illegal, 0);
      chk("t5_clr_seq", err_seq, 0);
      // clear on the same edge as a new error keeps the new one
      cycle(R, R, 1'b1);
      chk("t5_clr_new", error_count, 1);

      // T6: reset mid-RG, then a clean cycle
      do_reset();
      hold(pat(0), YL); hold(pat(1), 7);
      do_reset();
      ideal_cycle(); hold(pat(0), 1);
      chk("t6_cycles", cycles_done, 1);
      chk("t6_errors", error_count, 0);

      // Randomized controller-like traffic with perturbed durations and glitches
      do_reset();
      for (int seg = 0, ph = 0; seg < 120; seg++, ph = (ph + 1) % 4) begin
         int k;
         k = plen(ph) + (($urandom_range(0, 4) == 0) ? -1 : ($urandom_range(0, 4) == 0) ? 1 : 0);
         for (int i = 0; i < k; i++) begin
            v = pat(ph);
            if ($urandom_range(0, 40) == 0) v = rand_illegal();
            else if ($urandom_range(0, 60) == 0) v = pat($urandom_range(0, 3));
            cycle(v[5:3], v[2:0], $urandom_range(0, 50) == 0);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
